// File: rtl/link_tx_scheduler.sv
// Byte scheduler for an 8b/10b link: picks comma, K-char, SOF/EOF or data each cycle; one-cycle registered latency.
// Backpressure: d_ready/k_ack are combinational grants; K requests wait for frame end, data stalls for forced commas.
module link_tx_scheduler #(
    parameter int SYNC_PERIOD = 256,
    parameter int INIT_IDLES  = 16
) (
    input  logic       byte_clk,
    input  logic       rst,
    input  logic       d_valid,
    input  logic [7:0] d_data,
    input  logic       d_last,
    output logic       d_ready,
    input  logic       k_req,
    input  logic [7:0] k_code,
    output logic       k_ack,
    output logic [7:0] byte_out,
    output logic       is_k,
    output logic       idle,
    output logic       underrun
);

    localparam logic [7:0] COMMA_BYTE = 8'hBC;
    localparam logic [7:0] SOF_BYTE   = 8'h1C;
    localparam logic [7:0] EOF_BYTE   = 8'hFD;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DATA,
        ST_EOF
    } state_t;

    state_t      state;
    logic [7:0]  init_cnt;
    logic [15:0] cnt;
    logic        sync_due;

    assign sync_due = (cnt == 16'(SYNC_PERIOD));

    // Grants are gated by rst so nothing transfers on a reset edge.
    assign d_ready = !rst && (state == ST_DATA) && !sync_due;
    assign k_ack   = !rst && (state == ST_IDLE) && k_req;

    always_ff @(posedge byte_clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= 8'd0;
            cnt      <= 16'd0;
            byte_out <= COMMA_BYTE;
            is_k     <= 1'b1;
            idle     <= 1'b1;
            underrun <= 1'b0;
        end else begin
            // Comma is the default output; branches below override it.
            byte_out <= COMMA_BYTE;
            is_k     <= 1'b1;
            idle     <= 1'b1;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 8'd1;
                    if (init_cnt == 8'(INIT_IDLES - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (k_req) begin
                        byte_out <= k_code;
                        idle     <= 1'b0;
                    end else if (d_valid) begin
                        byte_out <= SOF_BYTE;
                        idle     <= 1'b0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sync_due) begin
                        cnt <= 16'd0;
                    end else if (d_valid) begin
                        byte_out <= d_data;
                        is_k     <= 1'b0;
                        idle     <= 1'b0;
                        cnt      <= cnt + 16'd1;
                        if (d_last) begin
                            state <= ST_EOF;
                        end
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                ST_EOF: begin
                    byte_out <= EOF_BYTE;
                    idle     <= 1'b0;
                    cnt      <= 16'd0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler with SYNC_PERIOD=4 so forced commas appear in short frames.
module tb_link_tx_scheduler;

    logic       byte_clk = 1'b0;
    logic       rst;
    logic       d_valid;
    logic [7:0] d_data;
    logic       d_last;
    logic       d_ready;
    logic       k_req;
    logic [7:0] k_code;
    logic       k_ack;
    logic [7:0] byte_out;
    logic       is_k;
    logic       idle;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    always #5 byte_clk = ~byte_clk;

    link_tx_scheduler #(.SYNC_PERIOD(4), .INIT_IDLES(16)) dut (
        .byte_clk (byte_clk),
        .rst      (rst),
        .d_valid  (d_valid),
        .d_data   (d_data),
        .d_last   (d_last),
        .d_ready  (d_ready),
        .k_req    (k_req),
        .k_code   (k_code),
        .k_ack    (k_ack),
        .byte_out (byte_out),
        .is_k     (is_k),
        .idle     (idle),
        .underrun (underrun)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge byte_clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [7:0] b, input logic k, input logic i);
        chk({tag, "_byte"}, byte_out, b);
        chk({tag, "_isk"}, {7'd0, is_k}, {7'd0, k});
        chk({tag, "_idle"}, {7'd0, idle}, {7'd0, i});
    endtask

    task automatic exp_comma(input string tag);
        exp_out(tag, 8'hBC, 1'b1, 1'b1);
    endtask

    // Presents one data byte, expects it granted, and checks it on the output.
    task automatic send(input string tag, input logic [7:0] d, input logic last);
        d_valid = 1'b1;
        d_data  = d;
        d_last  = last;
        chk({tag, "_rdy"}, {7'd0, d_ready}, 8'd1);
        cyc();
        exp_out(tag, d, 1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        d_valid = 1'b0;
        d_data  = 8'h00;
        d_last  = 1'b0;
        k_req   = 1'b0;
        k_code  = 8'h00;
        cyc();
        cyc();
        exp_comma("reset");
        chk("reset_underrun", {7'd0, underrun}, 8'd0);
        d_valid = 1'b1;
        k_req   = 1'b1;
        #1;
        chk("reset_rdy", {7'd0, d_ready}, 8'd0);
        chk("reset_kack", {7'd0, k_ack}, 8'd0);
        d_valid = 1'b0;
        k_req   = 1'b0;

        // Power-up: commas only, no grants.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("init_rdy", {7'd0, d_ready}, 8'd0);
            chk("init_kack", {7'd0, k_ack}, 8'd0);
            cyc();
            exp_comma("init");
        end

        // Simple frame 11,22,33.
        d_valid = 1'b1;
        d_data  = 8'h11;
        #1;
        chk("f1_idle_rdy", {7'd0, d_ready}, 8'd0);
        cyc();
        exp_out("f1_sof", 8'h1C, 1'b1, 1'b0);
        send("f1_d0", 8'h11, 1'b0);
        send("f1_d1", 8'h22, 1'b0);
        send("f1_d2", 8'h33, 1'b1);
        d_valid = 1'b0;
        d_last  = 1'b0;
        #1;
        chk("f1_eof_rdy", {7'd0, d_ready}, 8'd0);
        cyc();
        exp_out("f1_eof", 8'hFD, 1'b1, 1'b0);
        cyc();
        exp_comma("f1_after");
        chk("f1_underrun", {7'd0, underrun}, 8'd0);

        // K request beats data in IDLE.
        k_req   = 1'b1;
        k_code  = 8'hF7;
        d_valid = 1'b1;
        d_data  = 8'hAA;
        #1;
        chk("k_ack_hi", {7'd0, k_ack}, 8'd1);
        chk("k_rdy_lo", {7'd0, d_ready}, 8'd0);
        cyc();
        exp_out("k_byte", 8'hF7, 1'b1, 1'b0);
        k_req = 1'b0;
        #1;
        chk("k_ack_lo", {7'd0, k_ack}, 8'd0);
        cyc();
        exp_out("k_sof", 8'h1C, 1'b1, 1'b0);
        send("k_d0", 8'hAA, 1'b1);
        d_valid = 1'b0;
        d_last  = 1'b0;
        cyc();
        exp_out("k_eof", 8'hFD, 1'b1, 1'b0);
        cyc();
        exp_comma("k_after");

        // Ten-byte frame with forced commas every 4 bytes, then a back-to-back frame.
        d_valid = 1'b1;
        cyc();
        exp_out("s_sof", 8'h1C, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            send("s_data", 8'(8'h40 + i), (i == 10) ? 1'b1 : 1'b0);
            if (i == 4 || i == 8) begin
                chk("s_sync_rdy", {7'd0, d_ready}, 8'd0);
                cyc();
                exp_comma("s_sync");
            end
        end
        d_last = 1'b0;
        d_data = 8'h55;
        #1;
        chk("s_eof_rdy", {7'd0, d_ready}, 8'd0);
        cyc();
        exp_out("s_eof", 8'hFD, 1'b1, 1'b0);
        cyc();
        exp_out("b2b_sof", 8'h1C, 1'b1, 1'b0);
        // Last byte lands exactly on the sync boundary: EOF follows directly.
        for (int i = 1; i <= 4; i++) begin
            send("b2b_data", 8'(8'h60 + i), (i == 4) ? 1'b1 : 1'b0);
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
        cyc();
        exp_out("b2b_eof", 8'hFD, 1'b1, 1'b0);
        cyc();
        exp_comma("b2b_after");
        chk("b2b_underrun", {7'd0, underrun}, 8'd0);

        // Starved mid-frame, K raised during the frame.
        d_valid = 1'b1;
        cyc();
        exp_out("u_sof", 8'h1C, 1'b1, 1'b0);
        send("u_d0", 8'h81, 1'b0);
        d_valid = 1'b0;
        k_req   = 1'b1;
        k_code  = 8'hF7;
        #1;
        chk("u_kack_data", {7'd0, k_ack}, 8'd0);
        chk("u_rdy", {7'd0, d_ready}, 8'd1);
        cyc();
        exp_comma("u_fill0");
        chk("u_underrun_set", {7'd0, underrun}, 8'd1);
        cyc();
        exp_comma("u_fill1");
        send("u_d1", 8'h82, 1'b0);
        chk("u_kack_d1", {7'd0, k_ack}, 8'd0);
        send("u_d2", 8'h83, 1'b1);
        d_valid = 1'b0;
        d_last  = 1'b0;
        #1;
        chk("u_kack_eof", {7'd0, k_ack}, 8'd0);
        cyc();
        exp_out("u_eof", 8'hFD, 1'b1, 1'b0);
        chk("u_kack_idle", {7'd0, k_ack}, 8'd1);
        cyc();
        exp_out("u_kbyte", 8'hF7, 1'b1, 1'b0);
        k_req = 1'b0;
        cyc();
        exp_comma("u_after");
        chk("u_underrun_sticky", {7'd0, underrun}, 8'd1);

        // Reset mid-frame: no EOF, full init sequence, underrun cleared.
        d_valid = 1'b1;
        cyc();
        exp_out("r_sof", 8'h1C, 1'b1, 1'b0);
        send("r_d0", 8'h91, 1'b0);
        send("r_d1", 8'h92, 1'b0);
        rst = 1'b1;
        #1;
        chk("r_rst_rdy", {7'd0, d_ready}, 8'd0);
        chk("r_rst_kack", {7'd0, k_ack}, 8'd0);
        cyc();
        exp_comma("r_rst");
        chk("r_underrun", {7'd0, underrun}, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("r_init_rdy", {7'd0, d_ready}, 8'd0);
            cyc();
            exp_comma("r_init");
        end
        chk("r_idle_rdy", {7'd0, d_ready}, 8'd0);
        cyc();
        exp_out("r_sof2", 8'h1C, 1'b1, 1'b0);
        send("r_d2", 8'h77, 1'b1);
        d_valid = 1'b0;
        d_last  = 1'b0;
        cyc();
        exp_out("r_eof", 8'hFD, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
